// File: rtl/hmmm_programmer.sv
// ---------------------------------------------------------------------------
// hmmm_programmer
//
// Serialises Hmmm program words (8-bit address + 16-bit instruction) onto the
// two-wire programming interface of a Hmmm core.  An upstream source offers
// words through a valid/ready handshake into a one-entry holding register.
// The FSM drains that register into a shifter and emits one frame per word:
//
//    START : both lines 1                        (1 bit period)
//    SHIFT : 16 bit periods, index i = 15..0     (16 bit periods)
//            pgrm_data = data[i]
//            pgrm_addr = addr[i-8] for i >= 8, else 0
//    GAP   : both lines 0                        (1 bit period)
//
// One bit period is CLK_DIV clock cycles, so a frame is 18*CLK_DIV cycles.
// Frames run back to back when the holding register is already full at the
// end of GAP.
//
// Ports
//    clk        in   1   clock, all state on the rising edge
//    rst        in   1   synchronous active-high reset
//    wr_valid   in   1   upstream word offered
//    wr_ready   out  1   holding register empty
//    wr_addr    in   8   instruction-memory address
//    wr_data    in  16   instruction word
//    pgrm_addr  out  1   serial address line (registered)
//    pgrm_data  out  1   serial data line (registered)
//    busy       out  1   frame in flight or word waiting
//    words_sent out  9   completed frames, saturating at 511
// ---------------------------------------------------------------------------
module hmmm_programmer #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [7:0]  wr_addr,
   input  logic [15:0] wr_data,
   output logic        pgrm_addr,
   output logic        pgrm_data,
   output logic        busy,
   output logic [8:0]  words_sent
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   // Last divider value of a bit period.
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_e      state_q,     state_d;
   logic [7:0]  div_q,       div_d;
   logic [3:0]  bit_q,       bit_d;
   logic [7:0]  sh_addr_q,   sh_addr_d;
   logic [15:0] sh_data_q,   sh_data_d;
   logic        hold_full_q, hold_full_d;
   logic [7:0]  hold_addr_q, hold_addr_d;
   logic [15:0] hold_data_q, hold_data_d;
   logic [8:0]  words_q,     words_d;
   logic        line_addr_q, line_addr_d;
   logic        line_data_q, line_data_d;
   logic        busy_q,      busy_d;
   logic        ready_q,     ready_d;

   logic        period_end_s;
   logic        hold_clr_s;
   logic        accept_s;

   // Next-state, shifter, counter and holding-register logic.
   always_comb begin
      state_d      = state_q;
      div_d        = div_q + 8'd1;
      bit_d        = bit_q;
      sh_addr_d    = sh_addr_q;
      sh_data_d    = sh_data_q;
      words_d      = words_q;
      hold_clr_s   = 1'b0;
      period_end_s = (div_q == DIV_LAST);

      case (state_q)
         ST_IDLE: begin
            div_d = 8'd0;
            if (hold_full_q) begin
               sh_addr_d  = hold_addr_q;
               sh_data_d  = hold_data_q;
               hold_clr_s = 1'b1;
               state_d    = ST_START;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_START: begin
            if (period_end_s) begin
               div_d   = 8'd0;
               bit_d   = 4'd15;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_START;
            end
         end
         ST_SHIFT: begin
            if (period_end_s) begin
               div_d = 8'd0;
               if (bit_q == 4'd0) begin
                  state_d = ST_GAP;
               end else begin
                  bit_d   = bit_q - 4'd1;
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_GAP: begin
            if (period_end_s) begin
               div_d = 8'd0;
               if (words_q != 9'd511) begin
                  words_d = words_q + 9'd1;
               end else begin
                  words_d = words_q;
               end
               // A waiting word starts immediately, with no idle cycle.
               if (hold_full_q) begin
                  sh_addr_d  = hold_addr_q;
                  sh_data_d  = hold_data_q;
                  hold_clr_s = 1'b1;
                  state_d    = ST_START;
               end else begin
                  state_d    = ST_IDLE;
               end
            end else begin
               state_d = ST_GAP;
            end
         end
         default: begin
            div_d   = 8'd0;
            state_d = ST_IDLE;
         end
      endcase

      // Acceptance only depends on the registered hold flag, so a word that
      // arrives on the same edge the hold is drained waits for the next edge.
      accept_s = wr_valid & ~hold_full_q;
      if (accept_s) begin
         hold_full_d = 1'b1;
         hold_addr_d = wr_addr;
         hold_data_d = wr_data;
      end else if (hold_clr_s) begin
         hold_full_d = 1'b0;
         hold_addr_d = hold_addr_q;
         hold_data_d = hold_data_q;
      end else begin
         hold_full_d = hold_full_q;
         hold_addr_d = hold_addr_q;
         hold_data_d = hold_data_q;
      end
   end

   // Line, busy and ready values derived from the state being entered so
   // that the registered outputs describe the cycle after the edge.
   always_comb begin
      line_addr_d = 1'b0;
      line_data_d = 1'b0;
      case (state_d)
         ST_START: begin
            line_addr_d = 1'b1;
            line_data_d = 1'b1;
         end
         ST_SHIFT: begin
            line_data_d = sh_data_d[bit_d];
            // Upper half of the frame carries the address, lower half is 0.
            if (bit_d[3]) begin
               line_addr_d = sh_addr_d[bit_d[2:0]];
            end else begin
               line_addr_d = 1'b0;
            end
         end
         default: begin
            line_addr_d = 1'b0;
            line_data_d = 1'b0;
         end
      endcase
      busy_d  = (state_d != ST_IDLE) | hold_full_d;
      ready_d = ~hold_full_d;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         div_q       <= 8'd0;
         bit_q       <= 4'd0;
         sh_addr_q   <= 8'd0;
         sh_data_q   <= 16'd0;
         hold_full_q <= 1'b0;
         hold_addr_q <= 8'd0;
         hold_data_q <= 16'd0;
         words_q     <= 9'd0;
         line_addr_q <= 1'b0;
         line_data_q <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         sh_addr_q   <= sh_addr_d;
         sh_data_q   <= sh_data_d;
         hold_full_q <= hold_full_d;
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
         words_q     <= words_d;
         line_addr_q <= line_addr_d;
         line_data_q <= line_data_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
      end
   end

   assign pgrm_addr  = line_addr_q;
   assign pgrm_data  = line_data_q;
   assign busy       = busy_q;
   assign wr_ready   = ready_q;
   assign words_sent = words_q;

endmodule

// File: doc/hmmm_programmer.md
HMMM_PROGRAMMER -- requirements
Module: hmmm_programmer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1, meaning clock cycles per serial bit period; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port wr_valid, input, 1, meaning an upstream program word is offered.
REQ-005 SHALL have port wr_ready, output, 1, meaning the one-entry holding register is empty.
REQ-006 SHALL have port wr_addr, input, 8, meaning the Hmmm instruction-memory address, 0..255.
REQ-007 SHALL have port wr_data, input, 16, meaning the instruction word.
REQ-008 SHALL have port pgrm_addr, output, 1, the serial address line to the core's pgrm_addr input; registered.
REQ-009 SHALL have port pgrm_data, output, 1, the serial data line to the core's pgrm_data input; registered.
REQ-010 SHALL have port busy, output, 1, meaning the FSM is not IDLE or the holding register is full.
REQ-011 SHALL have port words_sent, output, 9, meaning the count of completed frames; saturates at 511.

Function
REQ-012 SHALL complete a handshake on any rising edge where wr_valid=1 and wr_ready=1, latching {wr_addr, wr_data} into the holding register.
REQ-013 SHALL set wr_ready = !hold_full, with no combinational path from wr_valid.
REQ-014 SHALL implement the FSM states IDLE, START, SHIFT and GAP.
REQ-015 In IDLE with hold_full=1, the FSM SHALL load the shifter from the holding register, clear hold_full and go to START on the same edge.
REQ-016 SHALL drive pgrm_addr=1 and pgrm_data=1 in START for CLK_DIV cycles, then go to SHIFT.
REQ-017 SHALL hold SHIFT for 16 bit periods of CLK_DIV cycles each, with bit index i = 15 down to 0.
REQ-018 During SHIFT, pgrm_data SHALL carry data[i], MSB first.
REQ-019 During SHIFT, pgrm_addr SHALL carry addr[i-8] for i = 15..8 (addr MSB first) and 0 for i = 7..0.
REQ-020 SHALL drive both lines 0 in GAP for CLK_DIV cycles.
REQ-021 At the end of GAP, the FSM SHALL increment words_sent, holding it at 511 once reached.
REQ-022 At the end of GAP, the FSM SHALL go directly to START, loading from the holding register, if hold_full=1; otherwise it SHALL go to IDLE.
REQ-023 SHALL drive both lines 0 in IDLE.
REQ-024 A frame SHALL last exactly 18*CLK_DIV cycles; back-to-back frames SHALL have no idle cycle between GAP and the next START.
REQ-025 Latency: for a handshake at edge N with the FSM in IDLE, the load SHALL occur at edge N+1 and the start bit SHALL appear on the lines in the cycle after edge N+1.
REQ-026 SHALL allow a simultaneous handshake and holding-register load only when hold was empty at edge start; the word accepted is retained and loaded next.
REQ-027 SHALL keep the shifter and lines unchanged by wr_* while a frame is in flight.
REQ-028 SHALL time bit periods with a divider counter of 8 bits that resets to 0 at every state or bit change.

Reset
REQ-029 On any edge with rst=1, the block SHALL enter IDLE and drive pgrm_addr=0, pgrm_data=0, hold_full=0, wr_ready=1, busy=0 and words_sent=0, including mid-frame; the partial frame is abandoned and not counted.
REQ-030 While rst=1, the block SHALL accept no handshake.

Verification
REQ-031 CLK_DIV=1, single word addr=0x05 data=0xA5C3 -> START, then pgrm_data=1010010111000011 and pgrm_addr=00000101_00000000, GAP 0; words_sent=1 after 18 cycles.
REQ-032 CLK_DIV=1, two words offered continuously -> second accepted while the first shifts; frames contiguous over 36 cycles; words_sent=2; wr_ready low only while hold is full.
REQ-033 CLK_DIV=4, addr=0xFF data=0x0001 -> each bit held 4 cycles, frame 72 cycles, last data bit 1 held 4 cycles.
REQ-034 rst asserted at cycle 7 of a frame -> lines 0 the next cycle, words_sent=0, wr_ready=1; a new word afterward produces a clean full frame.
REQ-035 512 frames sent -> words_sent reads 511 and stays 511.
REQ-036 wr_valid held high with hold full -> no acceptance; wr_addr/wr_data changes do not alter the in-flight bits.
